// File: rtl/sreg_pkg.sv
// Shared definitions for the serial shift-register link.
// Used by the PISO transmitter and the SIPO receiver so both sides agree
// on the state encoding and the default word width.
//
// Contents:
//   ST_IDLE / ST_SHIFT : transmitter state encoding
//   SREG_W             : default link word width in bits
package sreg_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam int SREG_W = 4;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, send side of the serial link.
// A word taken through the load handshake is shifted out LSB first, one bit
// per clock. A new word may be accepted on the cycle that carries the last
// bit of the current word, so consecutive words go out with no gap.
//
// Ports:
//   clk        : rising-edge clock
//   clear      : synchronous active-high reset, overrides every other input
//   din        : parallel word to transmit
//   load_valid : din is valid and requests transmission
//   load_ready : a word is accepted on this edge if load_valid is high
//   sout       : serial data bit
//   sout_valid : sout carries a word bit this cycle
//   done       : sout carries the last bit (MSB) of the current word
module piso_tx
   import sreg_pkg::*;
#(
   parameter  int WIDTH = SREG_W,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic             state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             accept;

   // State register: state, bit counter and shift register all move together,
   // and clear drops any word in flight without finishing it.
   always_ff @(posedge clk) begin
      if (clear) begin
         state <= ST_IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic. A load wins over everything, which is what lets a new
   // word follow the last bit of the old one directly. Otherwise the word
   // shifts right with zero fill until its last bit, then the block idles.
   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = cnt;
      accept  = load_valid && load_ready;
      if (accept) begin
         state_n = ST_SHIFT;
         shreg_n = din;
         cnt_n   = '0;
      end else if (state == ST_SHIFT) begin
         if (done) begin
            state_n = ST_IDLE;
            shreg_n = '0;
            cnt_n   = '0;
         end else begin
            shreg_n = {1'b0, shreg[WIDTH-1:1]};
            cnt_n   = cnt + CNT_W'(1);
         end
      end
   end

   // Outputs come straight from the state with no extra register stage.
   // Ready is also raised on the last bit so a follow-on word can load.
   always_comb begin
      sout_valid = (state == ST_SHIFT);
      sout       = sout_valid ? shreg[0] : 1'b0;
      done       = sout_valid && (cnt == LAST_CNT);
      load_ready = (state == ST_IDLE) || done;
   end

endmodule
